// File: rtl/img_matrix_3x3_if.sv
// Pixel stream in and 3x3 window stream out for img_matrix_3x3.
// The master drives raw pixels; the slave returns windows.
interface img_matrix_3x3_if #(
    parameter int DATA_W = 8
);
    logic              pre_img_vsync;
    logic              pre_img_hsync;
    logic              pre_img_valid;
    logic [DATA_W-1:0] pre_img_data;

    logic              matrix_img_vsync;
    logic              matrix_img_hsync;
    logic              matrix_img_valid;
    logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33;

    modport master (
        output pre_img_vsync, pre_img_hsync,
        output pre_img_valid, pre_img_data,
        input  matrix_img_vsync, matrix_img_hsync,
        input  matrix_img_valid,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );

    modport slave (
        input  pre_img_vsync, pre_img_hsync,
        input  pre_img_valid, pre_img_data,
        output matrix_img_vsync, matrix_img_hsync,
        output matrix_img_valid,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );
endinterface

// File: rtl/img_matrix_3x3.sv
// Streaming causal 3x3 neighbourhood generator with two line buffers.
// Two-cycle latency; rows above 0 and columns left of 0 read as zero.
module img_matrix_3x3 #(
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 720,
    parameter int DATA_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    img_matrix_3x3_if.slave  s
);
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam int unused_height = IMG_HEIGHT;

    logic [COL_W-1:0] col_cnt, cur_col;
    logic [10:0]      row_cnt, cur_row;
    logic             vs_d1, vs_d2, hs_d1, hs_d2;
    logic             restart, acc;

    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] rd1, rd2;

    logic              s1_valid, s1_r1, s1_r2, s1_c1, s1_c2;
    logic [DATA_W-1:0] s1_bot;
    logic [DATA_W-1:0] tap_top, tap_mid;

    logic              s2_valid;
    logic [DATA_W-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    assign acc     = s.pre_img_valid;
    assign restart = s.pre_img_vsync & ~vs_d1;
    // Restart wins over the running position for the pixel in that cycle.
    assign cur_col = restart ? '0 : col_cnt;
    assign cur_row = restart ? '0 : row_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1 <= 1'b0;
            vs_d2 <= 1'b0;
            hs_d1 <= 1'b0;
            hs_d2 <= 1'b0;
        end else begin
            vs_d1 <= s.pre_img_vsync;
            vs_d2 <= vs_d1;
            hs_d1 <= s.pre_img_hsync;
            hs_d2 <= hs_d1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (acc) begin
            if (cur_col == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (&cur_row) ? cur_row : cur_row + 11'd1;
            end else begin
                col_cnt <= cur_col + COL_W'(1);
                row_cnt <= cur_row;
            end
        end else if (restart) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end
    end

    // Line buffers hold no reset; stale data is masked by the row flags.
    always_ff @(posedge clk) begin
        if (acc) begin
            rd1          <= lb1[cur_col];
            rd2          <= lb2[cur_col];
            lb1[cur_col] <= s.pre_img_data;
            lb2[cur_col] <= lb1[cur_col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r1    <= 1'b0;
            s1_r2    <= 1'b0;
            s1_c1    <= 1'b0;
            s1_c2    <= 1'b0;
            s1_bot   <= '0;
        end else begin
            s1_valid <= acc;
            if (acc) begin
                s1_r1  <= (cur_row != 11'd0);
                s1_r2  <= (cur_row > 11'd1);
                s1_c1  <= (cur_col != '0);
                s1_c2  <= (cur_col > COL_W'(1));
                s1_bot <= s.pre_img_data;
            end
        end
    end

    assign tap_top = s1_r2 ? rd2 : '0;
    assign tap_mid = s1_r1 ? rd1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            p11 <= '0; p12 <= '0; p13 <= '0;
            p21 <= '0; p22 <= '0; p23 <= '0;
            p31 <= '0; p32 <= '0; p33 <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                p13 <= tap_top;
                p23 <= tap_mid;
                p33 <= s1_bot;
                p12 <= s1_c1 ? p13 : '0;
                p22 <= s1_c1 ? p23 : '0;
                p32 <= s1_c1 ? p33 : '0;
                p11 <= s1_c2 ? p12 : '0;
                p21 <= s1_c2 ? p22 : '0;
                p31 <= s1_c2 ? p32 : '0;
            end
        end
    end

    assign s.matrix_img_vsync = vs_d2;
    assign s.matrix_img_hsync = hs_d2;
    assign s.matrix_img_valid = s2_valid;
    assign s.matrix_p11 = p11;
    assign s.matrix_p12 = p12;
    assign s.matrix_p13 = p13;
    assign s.matrix_p21 = p21;
    assign s.matrix_p22 = p22;
    assign s.matrix_p23 = p23;
    assign s.matrix_p31 = p31;
    assign s.matrix_p32 = p32;
    assign s.matrix_p33 = p33;
endmodule

// File: tb/tb_img_matrix_3x3.sv
// Directed bench for img_matrix_3x3 on a 4-pixel-wide frame.
// Windows come from a position model plus hand-computed spot values.
module tb_img_matrix_3x3;
    localparam int W  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    always #5 clk = ~clk;

    img_matrix_3x3_if #(.DATA_W(DW)) bus ();

    img_matrix_3x3 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(4),
        .DATA_W    (DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .s    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic [71:0] got,
                       input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    wire [71:0] win_out = {
        bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
        bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
        bus.matrix_p31, bus.matrix_p32, bus.matrix_p33};

    typedef struct {
        int          idx;
        logic [71:0] w;
    } exp_t;

    exp_t        q[$];
    logic [71:0] cap [64];

    function automatic logic [71:0] model(input int r, input int c,
                                          input logic [7:0] base);
        logic [71:0] w;
        logic [7:0]  v;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int rr, cc;
                rr = r - 2 + i;
                cc = c - 2 + j;
                v = (rr >= 0 && cc >= 0) ? base + 8'(16 * rr + cc) : 8'h00;
                w = {w[63:0], v};
            end
        end
        return w;
    endfunction

    // Expected output sync/valid: inputs delayed by two clocks.
    logic dv1, dv2, dvs1, dvs2, dhs1, dhs2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {dv1, dv2, dvs1, dvs2, dhs1, dhs2} <= '0;
        end else begin
            dv1  <= bus.pre_img_valid;
            dv2  <= dv1;
            dvs1 <= bus.pre_img_vsync;
            dvs2 <= dvs1;
            dhs1 <= bus.pre_img_hsync;
            dhs2 <= dhs1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("valid_dly", 72'(bus.matrix_img_valid), 72'(dv2));
            chk("vsync_dly", 72'(bus.matrix_img_vsync), 72'(dvs2));
            chk("hsync_dly", 72'(bus.matrix_img_hsync), 72'(dhs2));
            if (bus.matrix_img_valid) begin
                if (q.size() == 0) begin
                    chk("extra_output", 72'(q.size()), 72'd1);
                end else begin
                    e = q.pop_front();
                    chk("window", win_out, e.w);
                    cap[e.idx] = win_out;
                end
            end
        end
    end

    task automatic px(input int r, input int c, input int idx,
                      input logic [7:0] base, input logic vs);
        exp_t e;
        @(posedge clk);
        #1;
        bus.pre_img_valid = 1'b1;
        bus.pre_img_hsync = 1'b1;
        bus.pre_img_vsync = vs;
        bus.pre_img_data  = base + 8'(16 * r + c);
        e.idx = idx;
        e.w   = model(r, c, base);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.pre_img_valid = 1'b0;
            bus.pre_img_hsync = 1'b0;
            bus.pre_img_vsync = 1'b0;
            bus.pre_img_data  = '0;
        end
    endtask

    task automatic vsync_pulse();
        @(posedge clk);
        #1;
        bus.pre_img_vsync = 1'b1;
        bus.pre_img_valid = 1'b0;
        bus.pre_img_hsync = 1'b0;
        idle(2);
    endtask

    task automatic frame(input logic [7:0] base, input int gap,
                         input int fidx);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                px(r, c, fidx * 16 + r * W + c, base, 1'b0);
                if (gap > 0) idle(gap);
            end
            idle(2);
        end
    endtask

    initial begin
        bus.pre_img_vsync = 1'b0;
        bus.pre_img_hsync = 1'b0;
        bus.pre_img_valid = 1'b0;
        bus.pre_img_data  = '0;
        for (int i = 0; i < 64; i++) cap[i] = 'x;

        // Reset held while pixels are offered.
        repeat (50) begin
            @(posedge clk);
            #1;
            bus.pre_img_valid = 1'b1;
            bus.pre_img_data  = 8'hAA;
            @(negedge clk);
            chk("rst_window", win_out, 72'h0);
            chk("rst_valid", 72'(bus.matrix_img_valid), 72'h0);
            chk("rst_sync",
                72'({bus.matrix_img_vsync, bus.matrix_img_hsync}), 72'h0);
        end
        @(posedge clk);
        #1;
        bus.pre_img_valid = 1'b0;
        bus.pre_img_data  = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Contiguous frame, value 16*r+c.
        vsync_pulse();
        frame(8'h00, 0, 0);
        idle(4);
        chk("f1_p00", cap[0], 72'h00_00_00_00_00_00_00_00_00);
        chk("f1_p10", cap[4], 72'h00_00_00_00_00_00_00_00_10);
        chk("f1_p11", cap[5], 72'h00_00_00_00_00_01_00_10_11);
        chk("f1_p22", cap[10], 72'h00_01_02_10_11_12_20_21_22);
        chk("f1_p33", cap[15], 72'h11_12_13_21_22_23_31_32_33);

        // Same frame with three idle cycles after each pixel.
        vsync_pulse();
        frame(8'h00, 3, 1);
        idle(4);
        chk("gap_p11", cap[21], 72'h00_00_00_00_00_01_00_10_11);
        chk("gap_p22", cap[26], 72'h00_01_02_10_11_12_20_21_22);

        // Second frame: stale buffer rows must be masked on row 0.
        vsync_pulse();
        frame(8'h80, 0, 2);
        idle(4);
        chk("f2_p01", cap[33], 72'h00_00_00_00_00_00_00_80_81);
        chk("f2_p02", cap[34], 72'h00_00_00_00_00_00_80_81_82);
        chk("f2_p22", cap[42], 72'h80_81_82_90_91_92_A0_A1_A2);

        // vsync rises mid-line together with a valid pixel.
        vsync_pulse();
        for (int c = 0; c < W; c++) px(0, c, 56 + c, 8'h30, 1'b0);
        px(1, 0, 60, 8'h30, 1'b0);
        px(1, 1, 61, 8'h30, 1'b0);
        px(0, 0, 48, 8'h55, 1'b1);
        px(0, 1, 49, 8'h55, 1'b1);
        px(0, 2, 50, 8'h55, 1'b1);
        idle(5);
        chk("rs_p00", cap[48], 72'h00_00_00_00_00_00_00_00_55);
        chk("rs_p02", cap[50], 72'h00_00_00_00_00_00_55_56_57);

        chk("queue_empty", 72'(q.size()), 72'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/img_matrix_3x3.md
# img_matrix_3x3

Streaming 3x3 neighbourhood generator for 8-bit grayscale video. It sits directly upstream of the average filter and of any other 3x3 window operator. It consumes the raw pixel stream (vsync/hsync/valid/data) and buffers two previous lines in on-chip line buffers. For every accepted pixel it emits one 3x3 window plus sync signals, all delayed to match.

## Interface
- IMG_WIDTH, 1280: active pixels per line; sets line-buffer depth and column-counter wrap.
- IMG_HEIGHT, 720: active lines per frame; informational only, used by verification for output counts.
- DATA_W, 8: pixel width.
- clk  in  1  pixel clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pre_img_vsync  in  1  frame sync, active high; a rising edge starts a new frame.
- pre_img_hsync  in  1  line sync, active high; pass-through only.
- pre_img_valid  in  1  pixel qualifier; one pixel accepted per high cycle.
- pre_img_data  in  DATA_W  pixel value.
- matrix_img_vsync  out  1  pre_img_vsync delayed 2 cycles.
- matrix_img_hsync  out  1  pre_img_hsync delayed 2 cycles.
- matrix_img_valid  out  1  window qualifier.
- matrix_p11..matrix_p33  out  DATA_W each  window outputs (9 ports).
  - Row index 1 = two lines up, 3 = current line.
  - Column index 1 = two pixels left, 3 = current pixel.

## Operation
- Counters:
  - col_cnt (0..IMG_WIDTH-1) increments on each accepted pixel and wraps to 0 after IMG_WIDTH-1.
  - On wrap, row_cnt increments; it saturates at 2047 (11 bits).
- Frame restart: a vsync rising edge (pre_img_vsync & ~registered vsync) clears col_cnt and row_cnt.
  - If valid is high in that same cycle, the pixel is accepted as (row 0, col 0). Restart takes priority over the increment.
  - A partial line in progress is discarded.
- Line buffers: two simple dual-port RAMs, lb1 and lb2, each IMG_WIDTH x DATA_W, addressed by col_cnt. On an accepted pixel D(r,c):
  - Read lb1[c] = D(r-1,c) and lb2[c] = D(r-2,c).
  - Write lb1[c] <= D(r,c) and lb2[c] <= old lb1[c].
- Stage 1 (registered, one cycle after accept) forms the column tap:
  - top = (r>=2) ? D(r-2,c) : 0
  - mid = (r>=1) ? D(r-1,c) : 0
  - bot = D(r,c)
  - Rows above row 0 therefore read as 0; stale buffer contents from the previous frame are masked.
- Stage 2 (registered) is a column shift register:
  - p13/p23/p33 = current tap.
  - p12/p22/p32 = previous tap if c>=1, else 0.
  - p11/p21/p31 = tap two back if c>=2, else 0.
  - It shifts only on stage-1 valid. At c==0 the left columns are loaded with 0.
- No right or bottom edge handling: the window is causal, with the bottom-right element equal to the current pixel.
- More than IMG_WIDTH pixels in a line wrap into a new row with no error indication.
- Arithmetic: no arithmetic on pixel data; counters have widths clog2(IMG_WIDTH) and 11 bits.

## Timing
- Latency: pre_img_valid at cycle N gives matrix_img_valid at N+2, with the window for that pixel. Exactly one output per input pixel.
- vsync and hsync go through the same 2-stage delay, so they stay aligned with valid.
- Gaps in pre_img_valid (within or between lines) reproduce as identical gaps on the output. Window contents do not change during a gap.
- Throughput: 1 pixel/cycle sustained, with no backpressure.
- Reset (rst_n low, asynchronous):
  - All outputs are 0; counters, sync delay lines and stage registers clear.
  - RAM contents are not reset; they are masked by row_cnt.
- Reset asserted mid-frame: outputs are 0 immediately. After release, the first accepted pixel is treated as (0,0) even without a vsync edge.

## Test plan
- Reset: hold rst_n low for 50 cycles while driving valid with data 0xAA. Required: all outputs 0 throughout; valid output never asserts.
- Small frame, IMG_WIDTH=4, pixel value 16*r+c, contiguous valid:
  - Window for (2,2): p11..p13=00,01,02; p21..p23=10,11,12; p31..p33=20,21,22.
  - Each window appears exactly 2 cycles after its input.
- Edges (same frame):
  - (0,0): p33=00, all others 0.
  - (1,0): p23=00, p33=10, p13 and columns 1-2 = 0.
  - (1,1): p22=00, p23=01, p32=10, p33=11, others 0.
- Valid gaps: the same 4-wide frame with 3 idle cycles after every pixel. Required: windows identical to the contiguous case; output valid pattern equals the input pattern shifted by 2.
- Frame restart:
  - Second frame with value 0x80+16*r+c: row 0 windows show 0 in rows 1-2 despite stale buffers.
  - vsync rising mid-line: the next pixel yields p33 only (position (0,0)).
- Full frame: 1280x720 ramp using the team's standard 1650x750 sync timing. Required:
  - 921600 output valids.
  - matrix_img_vsync/hsync equal the inputs delayed 2 cycles.
  - Every window matches a software model.
